dsp_sequencer: RTL

Frame-level instruction sequencer for `dsp_core`. On each sample-rate tick it walks program memory from address 0 and drives one instruction per clock onto the core's `instruction` input. It then feeds NOPs until the core pipeline has drained and signals frame completion. Between frames it arbitrates host access to parameter memory, so host writes never collide with a running frame, and it flags sample-rate overruns.

---
 rtl/dsp_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: frame-level instruction sequencer for dsp_core.
// On each sample tick it streams program memory from address 0 into the core,
// one word per clock. It then issues NOPs until the core pipeline drains and
// pulses frame_done. Between frames it grants the host access to parameter
// memory. Ticks that cannot be honoured are counted as overruns.
// Optional feature macro: DSP_SEQ_OVERRUN_COUNT_EN. When it is defined,
// overrun_count is a 16-bit saturating event counter. When it is not defined,
// overrun_count is tied to zero.
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPE_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic [PROG_ADDR_WIDTH:0]   prog_len,
  output logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr,
  output logic                       prog_rd_en,
  input  logic [INSTR_WIDTH-1:0]     prog_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  input  logic                       host_req,
  output logic                       host_gnt,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [15:0]                overrun_count
);

  localparam int LEN_W   = PROG_ADDR_WIDTH + 1;
  // The drain window covers every stage after decode plus the cycle that
  // carries frame_done, so the counter runs from 0 to PIPE_DEPTH+1.
  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 2);

  localparam logic [LEN_W-1:0]   MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOST  = 2'd3
  } state_t;

  state_t                     state_reg, state_next;
  logic [PROG_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]           len_reg, len_next;
  logic [DRAIN_W-1:0]         drain_cnt_reg, drain_cnt_next;
  logic                       pending_reg, pending_next;
  logic                       issue_reg;
  logic                       overrun_reg, overrun_next;

  logic [LEN_W-1:0]           len_clamped;
  logic                       busy_int;
  logic                       overrun_event;
  logic                       last_fetch;

  // Frame length sampled at frame start, capped at the size of program memory.
  assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

  assign busy_int = (state_reg == S_FETCH) || (state_reg == S_DRAIN);

  // A tick is lost if a frame is running or if a tick is already queued.
  assign overrun_event = sample_tick && (busy_int || pending_reg);

  // The last fetch issues address len-1. len is never zero in FETCH.
  assign last_fetch = ({1'b0, addr_reg} == (len_reg - LEN_W'(1)));

  // State and datapath registers for the frame walker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      drain_cnt_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      drain_cnt_reg <= drain_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  // Next-state logic. A tick, live or pending, beats a host request in IDLE.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    drain_cnt_next = drain_cnt_reg;
    pending_next   = pending_reg;
    case (state_reg)
      S_IDLE: begin
        if (sample_tick || pending_reg) begin
          // A pending tick is consumed here. A live tick in the same cycle is dropped.
          pending_next   = 1'b0;
          len_next       = len_clamped;
          addr_next      = '0;
          drain_cnt_next = '0;
          state_next     = (len_clamped == '0) ? S_DRAIN : S_FETCH;
        end else if (host_req) begin
          state_next = S_HOST;
        end
      end
      S_FETCH: begin
        addr_next = addr_reg + PROG_ADDR_WIDTH'(1);
        if (last_fetch) begin
          drain_cnt_next = '0;
          state_next     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = S_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
        end
      end
      S_HOST: begin
        // Only one tick can be queued while the host holds memory.
        if (sample_tick && !pending_reg) begin
          pending_next = 1'b1;
        end
        if (!host_req) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A read issued this cycle returns data next cycle, so this flag marks that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_reg <= 1'b0;
    end else begin
      issue_reg <= (state_reg == S_FETCH);
    end
  end

  // Program memory port and status outputs, decoded from the state.
  assign prog_rd_en   = (state_reg == S_FETCH);
  assign prog_rd_addr = (state_reg == S_FETCH) ? addr_reg : '0;
  assign busy         = busy_int;
  assign frame_done   = (state_reg == S_DRAIN) && (drain_cnt_reg == DRAIN_LAST);
  assign host_gnt     = (state_reg == S_HOST);

  // Pass the returned program word to the core only in the cycle after a read.
  // Every other cycle carries an all-zero NOP.
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_WIDTH; gi++) begin : g_instr_gate
      assign instruction[gi] = issue_reg & prog_rd_data[gi];
    end
  endgenerate

  // Sticky overrun flag. A new event takes priority over a clear in the same cycle.
  always_comb begin
    overrun_next = overrun_reg;
    if (overrun_event) begin
      overrun_next = 1'b1;
    end else if (overrun_clr) begin
      overrun_next = 1'b0;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= overrun_next;
    end
  end

  assign overrun = overrun_reg;

`ifdef DSP_SEQ_OVERRUN_COUNT_EN
  logic [15:0] overrun_count_reg, overrun_count_next;

  // Saturating event counter. A clear and an event in the same cycle leave a count of one.
  always_comb begin
    overrun_count_next = overrun_count_reg;
    if (overrun_clr) begin
      overrun_count_next = overrun_event ? 16'd1 : 16'd0;
    end else if (overrun_event && (overrun_count_reg != 16'hFFFF)) begin
      overrun_count_next = overrun_count_reg + 16'd1;
    end
  end

  // Overrun counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_count_reg <= 16'd0;
    end else begin
      overrun_count_reg <= overrun_count_next;
    end
  end

  assign overrun_count = overrun_count_reg;
`else
  assign overrun_count = 16'd0;
`endif

endmodule
